// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and data ports.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int INSTR_W      = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic [INSTR_W-1:0] if_rdata,
    output logic               if_ready,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               d_ready,
    output logic               m_req,
    output logic               m_we,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [DATA_W-1:0]  m_wdata,
    input  logic [DATA_W-1:0]  m_rdata,
    input  logic               m_ack
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
    state_t              state_q;
    logic                m_req_q, m_we_q, if_ready_q, d_ready_q, half_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q, d_rdata_q;
    logic [INSTR_W-1:0]  if_rdata_q;
    logic                pick_i_d, pick_d_d;
    logic                unused_bits;
    assign unused_bits = ^{if_addr[1:0], d_addr[2:0]};
`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] cnt_q;
    assign pick_i_d = if_req && (!d_req || cnt_q == 4'(STARVE_LIMIT));
    // Counts data grants that overtook a waiting fetch; only IDLE makes grants.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)
            cnt_q <= '0;
        else if (state_q == IDLE)
            cnt_q <= (!if_req || pick_i_d) ? 4'd0 : (d_req ? cnt_q + 4'd1 : cnt_q);
    end
`else
    localparam int unused_limit = STARVE_LIMIT;
    assign pick_i_d = if_req && !d_req;
`endif
    assign pick_d_d = d_req && !pick_i_d;
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            half_q     <= 1'b0;
            if_rdata_q <= '0;
            if_ready_q <= 1'b0;
            d_rdata_q  <= '0;
            d_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_d_d) begin
                        state_q   <= BUSY_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= d_we;
                        m_addr_q  <= {d_addr[ADDR_W-1:3], 3'b000};
                        m_wdata_q <= d_wdata;
                    end else if (pick_i_d) begin
                        state_q   <= BUSY_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= {if_addr[ADDR_W-1:3], 3'b000};
                        m_wdata_q <= '0;
                        half_q    <= if_addr[2];
                    end
                end
                BUSY_I: begin
                    if (m_ack) begin
                        state_q    <= RESP_I;
                        m_req_q    <= 1'b0;
                        if_ready_q <= 1'b1;
                        if_rdata_q <= half_q ? m_rdata[DATA_W-1:INSTR_W] : m_rdata[INSTR_W-1:0];
                    end
                end
                BUSY_D: begin
                    if (m_ack) begin
                        state_q   <= RESP_D;
                        m_req_q   <= 1'b0;
                        d_ready_q <= 1'b1;
                        d_rdata_q <= m_we_q ? d_rdata_q : m_rdata;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                end
            endcase
        end
    end
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign if_rdata = if_rdata_q;
    assign if_ready = if_ready_q;
    assign d_rdata  = d_rdata_q;
    assign d_ready  = d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter with a memory responder.
module tb_mem_port_arbiter;
    localparam int LIM = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
    logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
    logic [31:0] if_rdata;
    logic [63:0] d_rdata, m_addr, m_wdata;
    logic        if_ready, d_ready, m_req, m_we;
    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .CLOCK(clk), .RESET(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [63:0] mem[logic [63:0]];
    logic [63:0] ref_mem[logic [63:0]];
    logic [63:0] last_load = '0;
    function automatic logic [63:0] init_word(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0] + 32'd7};
    endfunction
    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction
    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata;} grant_t;
    grant_t glog[$];
    int lat = 1, busy = 0, last_busy = 0;
    logic [63:0] a0 = '0;

    // memory: acks after lat cycles of m_req, logs each grant once
    initial forever begin
        @(negedge clk);
        m_ack = 1'b0;
        if (!m_req) busy = 0;
        else begin
            busy++;
            if (busy == 1) begin
                a0 = m_addr;
                glog.push_back('{m_we, m_addr, m_wdata});
            end
            if (busy == lat) begin
                m_ack = 1'b1;
                m_rdata = mem_rd(m_addr);
                if (m_we) mem[m_addr] = m_wdata;
                last_busy = busy;
                chk("m_addr_stable", m_addr, a0);
            end
        end
    end

    logic [31:0] exp_if[$];
    logic [63:0] exp_d[$];
    logic prev_ir = 1'b0, prev_dr = 1'b0;
    initial forever begin
        @(negedge clk);
        if (if_ready) begin
            if (exp_if.size() == 0) begin
                checks++; errors++;
                $display("FAIL if_unexpected: if_ready with rdata %h, none expected", if_rdata);
            end else chk("if_rdata", 64'(if_rdata), 64'(exp_if.pop_front()));
            chk("if_ready_pulse", 64'(prev_ir), 64'd0);
        end
        if (d_ready) begin
            if (exp_d.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_unexpected: d_ready with rdata %h, none expected", d_rdata);
            end else chk("d_rdata", d_rdata, exp_d.pop_front());
            chk("d_ready_pulse", 64'(prev_dr), 64'd0);
        end
        prev_ir = if_ready;
        prev_dr = d_ready;
    end

    task automatic txn(input bit is_d, input bit we, input logic [63:0] a,
                       input logic [63:0] wd, output int cyc);
        logic [63:0] al, w;
        al = {a[63:3], 3'b000};
        if (is_d) begin
            if (we) ref_mem[al] = wd;
            else last_load = ref_rd(al);
            exp_d.push_back(last_load);
            d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
        end else begin
            w = ref_rd(al);
            exp_if.push_back(a[2] ? w[63:32] : w[31:0]);
            if_addr = a; if_req = 1'b1;
        end
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (is_d ? d_ready : if_ready) break;
            if (cyc > 100) begin
                checks++; errors++;
                $display("FAIL txn_timeout: no ready after %0d cycles, addr %h", cyc, a);
                break;
            end
        end
        @(posedge clk); #1;
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n, dr_cnt;
        bit gd, gi, is_i;
        logic [63:0] w;
        // reset with random inputs
        repeat (3) begin
            @(posedge clk); #1;
            if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
            if_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
            @(negedge clk);
            chk("reset_outputs", {m_req, m_we, if_ready, d_ready, |m_addr, |m_wdata, |if_rdata, |d_rdata}, 64'd0);
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_m_req", 64'(m_req), 64'd0);
        end
        @(posedge clk); #1;
        // fetch upper half, minimum latency
        mem[64'h0] = 64'hAAAABBBB_11112222;
        ref_mem[64'h0] = 64'hAAAABBBB_11112222;
        glog.delete();
        txn(0, 0, 64'h4, 64'h0, cyc);
        chk("t2_latency", 64'(cyc), 64'd3);
        chk("t2_if_rdata", 64'(if_rdata), 64'hAAAABBBB);
        chk("t2_grants", 64'(glog.size()), 64'd1);
        if (glog.size() >= 1) begin
            chk("t2_m_addr", glog[0].addr, 64'h0);
            chk("t2_m_we", 64'(glog[0].we), 64'd0);
        end
        // simultaneous requests: store first, then fetch
        glog.delete();
        ref_mem[64'h10] = 64'hDEAD;
        exp_d.push_back(last_load);
        w = ref_rd(64'h1000);
        exp_if.push_back(w[31:0]);
        d_we = 1'b1; d_addr = 64'h10; d_wdata = 64'hDEAD; if_addr = 64'h1000;
        d_req = 1'b1; if_req = 1'b1;
        gd = 0; gi = 0; n = 0;
        while (!(gd && gi)) begin
            @(negedge clk);
            n++;
            if (d_ready) gd = 1;
            if (if_ready) gi = 1;
            @(posedge clk); #1;
            if (gd) d_req = 1'b0;
            if (gi) if_req = 1'b0;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL t3_timeout: d_done %0d i_done %0d", gd, gi);
                d_req = 1'b0; if_req = 1'b0;
                break;
            end
        end
        chk("t3_grants", 64'(glog.size()), 64'd2);
        if (glog.size() >= 2) begin
            chk("t3_first_we", 64'(glog[0].we), 64'd1);
            chk("t3_first_addr", glog[0].addr, 64'h10);
            chk("t3_first_wdata", glog[0].wdata, 64'hDEAD);
            chk("t3_second_we", 64'(glog[1].we), 64'd0);
            chk("t3_second_addr", glog[1].addr, 64'h1000);
        end
        // wait states on a load
        lat = 5;
        txn(1, 0, 64'h18, 64'h0, cyc);
        chk("t4_m_req_cycles", 64'(last_busy), 64'd5);
        chk("t4_latency", 64'(cyc), 64'd7);
        chk("t4_d_rdata_hold", d_rdata, ref_rd(64'h18));
        lat = 1;
        // starvation: both held for 10 grants
        glog.delete();
        for (int g = 0; g < 10; g++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            is_i = ((g + 1) % (LIM + 1)) == 0;
`else
            is_i = 0;
`endif
            if (is_i) begin
                w = ref_rd(64'h1000);
                exp_if.push_back(w[63:32]);
            end else begin
                last_load = ref_rd(64'h2000);
                exp_d.push_back(last_load);
            end
        end
        d_we = 1'b0; d_addr = 64'h2000; if_addr = 64'h1004;
        d_req = 1'b1; if_req = 1'b1;
        n = 0;
        while (glog.size() < 10 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        d_req = 1'b0; if_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_grants", 64'(glog.size()), 64'd10);
        for (int g = 0; g < 10 && g < glog.size(); g++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            is_i = ((g + 1) % (LIM + 1)) == 0;
`else
            is_i = 0;
`endif
            chk($sformatf("t5_grant_%0d", g), glog[g].addr, is_i ? 64'h1000 : 64'h2000);
        end
        // reset in the middle of a busy load
        lat = 20;
        d_we = 1'b0; d_addr = 64'h2008; d_req = 1'b1;
        n = 0;
        while (!m_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_m_req_seen", 64'(m_req), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t6_m_req_async", 64'(m_req), 64'd0);
        d_req = 1'b0;
        dr_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            dr_cnt += int'(d_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_load = '0;
        lat = 1;
        repeat (2) begin
            @(negedge clk);
            dr_cnt += int'(d_ready);
        end
        chk("t6_no_d_ready", 64'(dr_cnt), 64'd0);
        @(posedge clk); #1;
        txn(0, 0, 64'h1008, 64'h0, cyc);
        chk("t6_fetch_latency", 64'(cyc), 64'd3);
        // randomized sequential traffic
        for (int k = 0; k < 40; k++) begin
            lat = 1 + int'($urandom % 4);
            txn(1'($urandom), 1'($urandom), 64'h3000 + 64'($urandom % 8) * 8 + 64'($urandom % 8),
                {$urandom, $urandom}, cyc);
            chk("rand_latency", 64'(cyc), 64'(lat + 2));
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_if.size() + exp_d.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
